gtfmac_vnc_reset_sequencer: RTL and testbench
=============================================

// Module: gtfmac_vnc_reset_sequencer
// PURPOSE
//  Drives the active-low resets into the per-domain reset syncers (the transmit end of the reset
//  path). Holds all domains in reset for a minimum width once the clock source is locked.
//  Releases the domains one stage at a time and waits for each domain's synchronized reset to
//  come back as an ack. Re-runs the sequence on a software request or on loss of lock.
// PARAMETERS
//  NUM_STAGES    3     number of reset domains, released in index order 0..NUM_STAGES-1 (>=1)
//  HOLD_CYCLES   16    minimum assert width, clk cycles with lock_s=1 (>=1)
//  STAGE_GAP     8     clk cycles between ack of stage k and release of stage k+1 (>=0)
//  ACK_TIMEOUT   1024  max clk cycles to wait for a stage ack (>=2)
//  SYNC_LEN      3     flop depth of the lock/ack input synchronizers (>=2)
// PORTS
//  clk           in   1           sequencer clock
//  reset_async   in   1           asynchronous, active-low reset
//  rst_req       in   1           clk-synchronous pulse; restarts the sequence
//  lock          in   1           async level; PLL/GT locked
//  stage_ack     in   NUM_STAGES  async levels; far-domain syncer output (1 = domain out of reset)
//  reset_n_out   out  NUM_STAGES  active-low reset to each far-domain syncer, registered
//  busy          out  1           1 in any state other than RUN
//  done          out  1           1 only in RUN
//  timeout_err   out  1           sticky; set on ack timeout, cleared by rst_req
// BEHAVIOUR
//  - Reset (reset_async=0, async): reset_n_out=0, busy=1, done=0, timeout_err=0. State=ASSERT.
//    All counters and synchronizer flops are 0.
//  - lock_s / ack_s: SYNC_LEN-flop synchronized copies of lock / stage_ack. All FSM decisions use
//    these copies only.
//  - ASSERT: reset_n_out=0. hold_cnt increments on each cycle with lock_s=1 and clears when
//    lock_s=0.
//    - On the edge where hold_cnt==HOLD_CYCLES-1 and lock_s=1: stg=0, reset_n_out[0]=1 at that
//      edge, go to WAIT_ACK.
//  - WAIT_ACK(stg): to_cnt increments every cycle.
//    - ack_s[stg]=1 seen at edge n:
//      - stg last: RUN at n+1.
//      - STAGE_GAP=0: reset_n_out[stg+1]=1 at n+1.
//      - Otherwise: GAP, and reset_n_out[stg+1]=1 at edge n+STAGE_GAP+1.
//    - An ack that is already high is accepted on the first WAIT_ACK cycle.
//    - to_cnt==ACK_TIMEOUT-1 with no ack: timeout_err=1, all reset_n_out=0, go to ASSERT, and
//      hold_cnt clears. The sequence retries automatically.
//  - GAP: counts STAGE_GAP cycles, then stg++ and reset_n_out[stg]=1 (released stages stay 1).
//  - RUN: done=1, busy=0. An ack falling in RUN is ignored.
//  - rst_req=1 in any state: at the next edge all reset_n_out=0, timeout_err=0, state ASSERT,
//    hold_cnt=0. This has priority over ack, timeout and GAP expiry on the same edge.
//  - lock_s=0 in WAIT_ACK/GAP/RUN: at the next edge all reset_n_out=0 and state ASSERT.
//    timeout_err is kept.
//  - Counters saturate and never wrap. Widths come from $clog2 of the parameter plus 1.
// CONFIGURATION
//  GTFMAC_VNC_RST_SEQ_DBG_EN defined: adds two output ports.
//  - dbg_seq_cnt [15:0]: saturating count of entries into RUN.
//  - dbg_to_stage [$clog2(NUM_STAGES+1)-1:0]: stage index of the last timeout.
//  - Both reset to 0, and rst_req does not clear them.
//  GTFMAC_VNC_RST_SEQ_DBG_EN undefined: the ports and their logic are absent. Behaviour is
//  otherwise identical.
// STRUCTURE
//  - Package gtfmac_vnc_rst_seq_pkg:
//    - typedef enum logic [1:0] {ASSERT, WAIT_ACK, GAP, RUN} rst_seq_state_t.
//    - Counter-width helper functions.
//  - Sub-module gtfmac_vnc_sync_level:
//    - Parameter WIDTH; SYNC_LEN flops per bit, ASYNC_REG, async clear on reset_async.
//    - Two instances: lock (WIDTH=1) and stage_ack (WIDTH=NUM_STAGES).
// TESTING
//  Bench model: each stage_ack[k] echoes reset_n_out[k] delayed 3 clk cycles.
//  Default parameters unless a scenario states otherwise.
//  1. Release reset_async with lock=1 held -> reset_n_out[0] rises on rising edge
//     SYNC_LEN+HOLD_CYCLES=19 after release; busy=1 and done=0 until RUN.
//  2. Full sequence -> reset_n_out[k+1] rises exactly STAGE_GAP+1=9 edges after ack_s[k] is seen;
//     after stage 2 acks, done=1 and busy=0. Repeat with STAGE_GAP=0 and check a gap of 1 edge.
//  3. stage_ack[1] held at 0 -> 1024 cycles after reset_n_out[1] rises, timeout_err=1 and
//     reset_n_out=3'b000; the sequence restarts. A following rst_req clears timeout_err.
//  4. rst_req pulse during GAP, coincident with expiry of the gap count -> next edge
//     reset_n_out=0, no further stage released, and the hold restarts for the full 16 cycles.
//  5. lock low for 5 cycles while in RUN -> all reset_n_out=0 within SYNC_LEN+1 edges.
//     The hold count begins only once lock_s returns to 1.
//  6. reset_async low mid-WAIT_ACK -> reset_n_out=0 with no clk edge;
//     with GTFMAC_VNC_RST_SEQ_DBG_EN defined, dbg_seq_cnt=0.

Source files
------------

// File: rtl/gtfmac_vnc_reset_sequencer_pkg.sv
// gtfmac_vnc_rst_seq_pkg: shared state encoding and counter sizing for the reset sequencer
package gtfmac_vnc_rst_seq_pkg;
  typedef enum logic [1:0] {ASSERT, WAIT_ACK, GAP, RUN} rst_seq_state_t;
  function automatic int cnt_w(input int v);
    return $clog2(v) + 1;
  endfunction
  function automatic int dbg_stg_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/gtfmac_vnc_sync_level.sv
// gtfmac_vnc_sync_level: multi-flop level synchronizer, cleared by the async reset
module gtfmac_vnc_sync_level #(
  parameter int WIDTH    = 1,
  parameter int SYNC_LEN = 3
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  (* ASYNC_REG = "TRUE" *) logic [SYNC_LEN-1:0][WIDTH-1:0] sync_q;
  // shift the raw level through SYNC_LEN flops
  always_ff @(posedge clk or negedge reset_async)
    if (!reset_async) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_LEN-2:0], d_i};
  assign q_o = sync_q[SYNC_LEN-1];
endmodule

// File: rtl/gtfmac_vnc_reset_sequencer.sv
// gtfmac_vnc_reset_sequencer: staged reset release with ack wait; GTFMAC_VNC_RST_SEQ_DBG_EN adds debug counters
module gtfmac_vnc_reset_sequencer
  import gtfmac_vnc_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 1024,
  parameter int SYNC_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  reset_async,
  input  logic                  rst_req,
  input  logic                  lock,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] reset_n_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
  ,
  output logic [15:0]                          dbg_seq_cnt,
  output logic [dbg_stg_w(NUM_STAGES)-1:0]     dbg_to_stage
`endif
);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int TO_W   = cnt_w(ACK_TIMEOUT);
  localparam int GAP_W  = cnt_w(STAGE_GAP);
  localparam int STG_W  = cnt_w(NUM_STAGES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NUM_STAGES - 1);

  rst_seq_state_t state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [STG_W-1:0]      stg_q, stg_d, stg_nxt;
  logic [NUM_STAGES-1:0] rn_q, rn_d, ack_s, nxt_bit;
  logic                  terr_q, terr_d, lock_s, ack_hit;

  gtfmac_vnc_sync_level #(.WIDTH(1), .SYNC_LEN(SYNC_LEN)) u_lock_sync (
    .clk(clk), .reset_async(reset_async), .d_i(lock), .q_o(lock_s)
  );
  gtfmac_vnc_sync_level #(.WIDTH(NUM_STAGES), .SYNC_LEN(SYNC_LEN)) u_ack_sync (
    .clk(clk), .reset_async(reset_async), .d_i(stage_ack), .q_o(ack_s)
  );

  assign ack_hit = |(ack_s & (NUM_STAGES'(1) << stg_q));
  assign stg_nxt = stg_q + STG_W'(1);
  assign nxt_bit = NUM_STAGES'(1) << stg_nxt;

  // next state: rst_req beats lock loss, which beats ack/timeout/gap expiry
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    gap_d   = gap_q;
    stg_d   = stg_q;
    rn_d    = rn_q;
    terr_d  = terr_q;
    if (rst_req) begin
      state_d = ASSERT;
      rn_d    = '0;
      hold_d  = '0;
      terr_d  = 1'b0;
    end else if (state_q != ASSERT && !lock_s) begin
      state_d = ASSERT;
      rn_d    = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ASSERT: begin
          hold_d = lock_s ? hold_q + HOLD_W'(hold_q != '1) : '0;
          if (lock_s && hold_q == HOLD_LAST) begin
            state_d = WAIT_ACK;
            stg_d   = '0;
            rn_d    = NUM_STAGES'(1);
            to_d    = '0;
          end
        end
        WAIT_ACK: begin
          to_d = to_q + TO_W'(to_q != '1);
          if (ack_hit) begin
            if (stg_q == STG_LAST) state_d = RUN;
            else if (STAGE_GAP == 0) begin
              stg_d = stg_nxt;
              rn_d  = rn_q | nxt_bit;
              to_d  = '0;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else if (to_q == TO_LAST) begin
            state_d = ASSERT;
            rn_d    = '0;
            hold_d  = '0;
            terr_d  = 1'b1;
          end
        end
        GAP: begin
          gap_d = gap_q + GAP_W'(gap_q != '1);
          if (gap_q == GAP_LAST) begin
            state_d = WAIT_ACK;
            stg_d   = stg_nxt;
            rn_d    = rn_q | nxt_bit;
            to_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // sequencer state and registered reset outputs
  always_ff @(posedge clk or negedge reset_async)
    if (!reset_async) begin
      state_q <= ASSERT;
      hold_q  <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      stg_q   <= '0;
      rn_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      stg_q   <= stg_d;
      rn_q    <= rn_d;
      terr_q  <= terr_d;
    end

  assign reset_n_out = rn_q;
  assign busy        = state_q != RUN;
  assign done        = state_q == RUN;
  assign timeout_err = terr_q;

`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
  logic to_hit;
  assign to_hit = state_q == WAIT_ACK && !rst_req && lock_s && !ack_hit && to_q == TO_LAST;
  // debug history survives rst_req; only reset_async clears it
  always_ff @(posedge clk or negedge reset_async)
    if (!reset_async) begin
      dbg_seq_cnt  <= '0;
      dbg_to_stage <= '0;
    end else begin
      dbg_seq_cnt  <= dbg_seq_cnt + 16'(state_d == RUN && state_q != RUN && dbg_seq_cnt != '1);
      dbg_to_stage <= to_hit ? dbg_stg_w(NUM_STAGES)'(stg_q) : dbg_to_stage;
    end
`endif
endmodule

// File: tb/tb_gtfmac_vnc_reset_sequencer.sv
// tb_gtfmac_vnc_reset_sequencer: directed scoreboard bench, STAGE_GAP=8 and STAGE_GAP=0 instances
module tb_gtfmac_vnc_reset_sequencer;
  logic clk = 1'b0, reset_async, rst_req, lock;
  logic [2:0] ack_en, ack0, ack1, rn0, rn1;
  logic busy0, done0, terr0, busy1, done1, terr1;
  logic [8:0] d0, d1;
`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
  logic [15:0] dsc0, dsc1;
  logic [1:0]  dts0, dts1;
`endif

  typedef struct {
    int          c;
    int          u;
    logic [31:0] x;
    string       tag;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  gtfmac_vnc_reset_sequencer u0 (
    .clk(clk), .reset_async(reset_async), .rst_req(rst_req), .lock(lock), .stage_ack(ack0),
    .reset_n_out(rn0), .busy(busy0), .done(done0), .timeout_err(terr0)
`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
    , .dbg_seq_cnt(dsc0), .dbg_to_stage(dts0)
`endif
  );
  gtfmac_vnc_reset_sequencer #(.STAGE_GAP(0)) u1 (
    .clk(clk), .reset_async(reset_async), .rst_req(rst_req), .lock(lock), .stage_ack(ack1),
    .reset_n_out(rn1), .busy(busy1), .done(done1), .timeout_err(terr1)
`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
    , .dbg_seq_cnt(dsc1), .dbg_to_stage(dts1)
`endif
  );

  // far-domain model: each ack echoes its reset_n_out three clk cycles later
  always_ff @(posedge clk or negedge reset_async)
    if (!reset_async) begin
      d0 <= '0;
      d1 <= '0;
    end else begin
      d0 <= {d0[5:0], rn0};
      d1 <= {d1[5:0], rn1};
    end
  assign ack0 = d0[8:6] & ack_en;
  assign ack1 = d1[8:6] & ack_en;

  function automatic logic [31:0] pk(input logic [2:0] rn, input logic b, input logic d, input logic t);
    return {26'b0, rn, b, d, t};
  endfunction

  function automatic logic [31:0] obs(input int u);
    return u != 0 ? pk(rn1, busy1, done1, terr1) : pk(rn0, busy0, done0, terr0);
  endfunction

  task automatic chk(input logic [31:0] o, input logic [31:0] x, input string tag);
    ncmp++;
    assert (o === x) else begin
      nerr++;
      $error("FAIL %s: got %0h required %0h", tag, o, x);
    end
  endtask

  task automatic e(input int c, input int u, input logic [2:0] rn, input logic b, input logic d,
                   input logic t, input string tag);
    sb.push_back('{c, u, pk(rn, b, d, t), tag});
  endtask

  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() != 0 && sb[0].c <= cyc) begin
      x = sb.pop_front();
      chk(obs(x.u), x.x, x.tag);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    reset_async = 1'b0;
    rst_req     = 1'b0;
    lock        = 1'b0;
    ack_en      = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk(obs(0), pk(3'b000, 1, 0, 0), "reset_u0");
    chk(obs(1), pk(3'b000, 1, 0, 0), "reset_u1");
    lock = 1'b1;
    @(negedge clk);
    reset_async = 1'b1;
    cyc = 0;
    e(18, 0, 3'b000, 1, 0, 0, "hold_u0");
    e(18, 1, 3'b000, 1, 0, 0, "hold_u1");
    e(19, 0, 3'b001, 1, 0, 0, "rel0_u0");
    e(19, 1, 3'b001, 1, 0, 0, "rel0_u1");
    e(25, 1, 3'b001, 1, 0, 0, "pre_rel1_u1");
    e(26, 1, 3'b011, 1, 0, 0, "rel1_gap0_u1");
    e(32, 1, 3'b011, 1, 0, 0, "pre_rel2_u1");
    e(33, 1, 3'b111, 1, 0, 0, "rel2_gap0_u1");
    e(33, 0, 3'b001, 1, 0, 0, "pre_rel1_u0");
    e(34, 0, 3'b011, 1, 0, 0, "rel1_u0");
    e(39, 1, 3'b111, 1, 0, 0, "pre_run_u1");
    e(40, 1, 3'b111, 0, 1, 0, "run_u1");
    e(48, 0, 3'b011, 1, 0, 0, "pre_rel2_u0");
    e(49, 0, 3'b111, 1, 0, 0, "rel2_u0");
    e(55, 0, 3'b111, 1, 0, 0, "pre_run_u0");
    e(56, 0, 3'b111, 0, 1, 0, "run_u0");
    run_to(60);
    lock = 1'b0;
    e(63, 0, 3'b111, 0, 1, 0, "lock_lo_pre_u0");
    e(63, 1, 3'b111, 0, 1, 0, "lock_lo_pre_u1");
    e(64, 0, 3'b000, 1, 0, 0, "lock_lo_u0");
    e(64, 1, 3'b000, 1, 0, 0, "lock_lo_u1");
    run_to(65);
    lock = 1'b1;
    e(83, 0, 3'b000, 1, 0, 0, "relock_hold_u0");
    e(83, 1, 3'b000, 1, 0, 0, "relock_hold_u1");
    e(84, 0, 3'b001, 1, 0, 0, "relock_rel0_u0");
    e(84, 1, 3'b001, 1, 0, 0, "relock_rel0_u1");
    e(97, 1, 3'b011, 1, 0, 0, "relock_rel1_u1");
    e(98, 0, 3'b001, 1, 0, 0, "gap_end_pre_u0");
    e(98, 1, 3'b111, 1, 0, 0, "relock_rel2_u1");
    run_to(98);
    rst_req = 1'b1;
    e(99, 0, 3'b000, 1, 0, 0, "req_gap_u0");
    e(99, 1, 3'b000, 1, 0, 0, "req_wait_u1");
    e(100, 0, 3'b000, 1, 0, 0, "req_no_rel_u0");
    e(114, 0, 3'b000, 1, 0, 0, "req_hold_u0");
    e(114, 1, 3'b000, 1, 0, 0, "req_hold_u1");
    e(115, 0, 3'b001, 1, 0, 0, "req_rel0_u0");
    e(115, 1, 3'b001, 1, 0, 0, "req_rel0_u1");
    step();
    rst_req = 1'b0;
    run_to(115);
    ack_en = 3'b101;
    e(1145, 1, 3'b011, 1, 0, 0, "pre_to_u1");
    e(1146, 1, 3'b000, 1, 0, 1, "to_u1");
    e(1153, 0, 3'b011, 1, 0, 0, "pre_to_u0");
    e(1154, 0, 3'b000, 1, 0, 1, "to_u0");
    e(1161, 1, 3'b000, 1, 0, 1, "retry_hold_u1");
    e(1162, 1, 3'b001, 1, 0, 1, "retry_rel0_u1");
    e(1169, 0, 3'b000, 1, 0, 1, "retry_hold_u0");
    e(1170, 0, 3'b001, 1, 0, 1, "retry_rel0_u0");
    e(1175, 0, 3'b001, 1, 0, 1, "sticky_u0");
    e(1175, 1, 3'b011, 1, 0, 1, "sticky_u1");
    run_to(1175);
    rst_req = 1'b1;
    e(1176, 0, 3'b000, 1, 0, 0, "req_clr_u0");
    e(1176, 1, 3'b000, 1, 0, 0, "req_clr_u1");
    step();
    rst_req = 1'b0;
    run_to(1185);
    ack_en = 3'b111;
    e(1191, 0, 3'b000, 1, 0, 0, "seq3_hold_u0");
    e(1191, 1, 3'b000, 1, 0, 0, "seq3_hold_u1");
    e(1192, 0, 3'b001, 1, 0, 0, "seq3_rel0_u0");
    e(1192, 1, 3'b001, 1, 0, 0, "seq3_rel0_u1");
    e(1199, 1, 3'b011, 1, 0, 0, "seq3_rel1_u1");
    e(1207, 0, 3'b011, 1, 0, 0, "seq3_rel1_u0");
    run_to(1210);
`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
    chk(32'(dsc0), 32'd1, "dbg_cnt_u0");
    chk(32'(dsc1), 32'd1, "dbg_cnt_u1");
    chk(32'(dts0), 32'd1, "dbg_stage_u0");
    chk(32'(dts1), 32'd1, "dbg_stage_u1");
`endif
    #1;
    reset_async = 1'b0;
    #1;
    chk(obs(0), pk(3'b000, 1, 0, 0), "async_rst_u0");
    chk(obs(1), pk(3'b000, 1, 0, 0), "async_rst_u1");
`ifdef GTFMAC_VNC_RST_SEQ_DBG_EN
    chk(32'(dsc0), 32'd0, "dbg_cnt_rst_u0");
    chk(32'(dts1), 32'd0, "dbg_stage_rst_u1");
`endif
    chk(32'(sb.size()), 32'd0, "sb_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
